// File: rtl/reg_file_2r1w_pkg.sv
// Shared constants and helpers for the 2-read/1-write register file.
// Default geometry matches a 32 x 32-bit integer register set.
package reg_file_2r1w_pkg;

   localparam int unsigned WORD_W   = 32;
   localparam int unsigned REG_N    = 32;
   localparam int unsigned ZERO_IDX = 0;

   // Ceiling log2, never below 1 so a 2-entry file still gets a 1-bit address.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(value)) begin
         r = r + 1;
      end
      if (r == 0) begin
         r = 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/reg_file_2r1w_rd_port.sv
// Combinational read port: storage mux with hardwired-zero entry and
// optional same-cycle write bypass.
module reg_file_rd_port
   import reg_file_2r1w_pkg::*;
#(
   parameter int unsigned WIDTH    = WORD_W,
   parameter int unsigned DEPTH    = REG_N,
   parameter int unsigned AW       = clog2(DEPTH),
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b0
) (
   input  logic [WIDTH-1:0] mem_i [DEPTH],
   input  logic [AW-1:0]    raddr_i,
   input  logic             wr_eff_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic is_zero_s;
   logic hit_s;

   assign is_zero_s = ZERO_REG && (raddr_i == AW'(ZERO_IDX));
   assign hit_s     = BYPASS && wr_eff_i && (raddr_i == waddr_i);

   // Zero entry wins over bypass, bypass wins over stored data.
   always_comb begin
      rdata_o = mem_i[raddr_i];
      if (is_zero_s) begin
         rdata_o = '0;
      end else if (hit_s) begin
         rdata_o = wdata_i;
      end else begin
         rdata_o = mem_i[raddr_i];
      end
   end

endmodule

// File: rtl/reg_file_2r1w.sv
// Register file: DEPTH x WIDTH storage, two async read ports, one sync write
// port, plus an effective-write counter with a sticky wrap flag.
module reg_file_2r1w
   import reg_file_2r1w_pkg::*;
#(
   parameter  int unsigned WIDTH    = WORD_W,
   parameter  int unsigned DEPTH    = REG_N,
   parameter  bit          ZERO_REG = 1'b1,
   parameter  bit          BYPASS   = 1'b0,
   parameter  int unsigned CNT_W    = 16,
   localparam int unsigned AW       = clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr1_i,
   input  logic [AW-1:0]    raddr2_i,
   output logic [WIDTH-1:0] rdata1_o,
   output logic [WIDTH-1:0] rdata2_o,
   output logic [CNT_W-1:0] wcount_o,
   output logic             wovf_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             wr_eff_s;

   // Gating with rst_ni keeps the bypass path quiet while reset is held.
   assign wr_eff_s = rst_ni && we_i && !(ZERO_REG && (waddr_i == AW'(ZERO_IDX)));

   // Write decode into next-state storage.
   always_comb begin
      mem_d = mem_q;
      if (wr_eff_s) begin
         mem_d[waddr_i] = wdata_i;
      end else begin
         mem_d = mem_q;
      end
   end

   // Storage array.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   // Counter next state; the flag latches on the all-ones to zero wrap.
   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (wr_eff_s) begin
         cnt_d = cnt_q + CNT_W'(1);
         if (cnt_q == '1) begin
            ovf_d = 1'b1;
         end else begin
            ovf_d = ovf_q;
         end
      end else begin
         cnt_d = cnt_q;
         ovf_d = ovf_q;
      end
   end

   // Counter and overflow flag registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign wcount_o = cnt_q;
   assign wovf_o   = ovf_q;

   reg_file_rd_port #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .AW       (AW),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
   ) u_rd1 (
      .mem_i    (mem_q),
      .raddr_i  (raddr1_i),
      .wr_eff_i (wr_eff_s),
      .waddr_i  (waddr_i),
      .wdata_i  (wdata_i),
      .rdata_o  (rdata1_o)
   );

   reg_file_rd_port #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .AW       (AW),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
   ) u_rd2 (
      .mem_i    (mem_q),
      .raddr_i  (raddr2_i),
      .wr_eff_i (wr_eff_s),
      .waddr_i  (waddr_i),
      .wdata_i  (wdata_i),
      .rdata_o  (rdata2_o)
   );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w across three parameter sets sharing clock
// and reset.
module tb_reg_file_2r1w;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        we_a;
   logic [4:0]  waddr_a, ra1_a, ra2_a;
   logic [31:0] wdata_a;
   logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1;
   logic [15:0] wc_0;
   logic [3:0]  wc_1;
   logic        wo_0, wo_1;

   logic        we_b;
   logic [1:0]  waddr_b, ra1_b, ra2_b;
   logic [7:0]  wdata_b, rd1_b, rd2_b;
   logic [15:0] wc_b;
   logic        wo_b;

   int errors = 0;
   int checks = 0;

   // Default geometry: zero register on, no bypass, 16-bit counter.
   reg_file_2r1w #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b0), .CNT_W(16)) u_dut0 (
      .clk_i(clk), .rst_ni(rst_n), .we_i(we_a), .waddr_i(waddr_a), .wdata_i(wdata_a),
      .raddr1_i(ra1_a), .raddr2_i(ra2_a), .rdata1_o(rd1_0), .rdata2_o(rd2_0),
      .wcount_o(wc_0), .wovf_o(wo_0));

   // Ordinary entry 0, bypass on, 4-bit counter to exercise the wrap.
   reg_file_2r1w #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b0), .BYPASS(1'b1), .CNT_W(4)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n), .we_i(we_a), .waddr_i(waddr_a), .wdata_i(wdata_a),
      .raddr1_i(ra1_a), .raddr2_i(ra2_a), .rdata1_o(rd1_1), .rdata2_o(rd2_1),
      .wcount_o(wc_1), .wovf_o(wo_1));

   // Small geometry with zero register and bypass both on.
   reg_file_2r1w #(.WIDTH(8), .DEPTH(4), .ZERO_REG(1'b1), .BYPASS(1'b1), .CNT_W(16)) u_dut2 (
      .clk_i(clk), .rst_ni(rst_n), .we_i(we_b), .waddr_i(waddr_b), .wdata_i(wdata_b),
      .raddr1_i(ra1_b), .raddr2_i(ra2_b), .rdata1_o(rd1_b), .rdata2_o(rd2_b),
      .wcount_o(wc_b), .wovf_o(wo_b));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic wr_a(input logic [4:0] a, input logic [31:0] d);
      we_a = 1'b1; waddr_a = a; wdata_a = d;
      @(posedge clk); #1;
      we_a = 1'b0;
   endtask

   task automatic wr_b(input logic [1:0] a, input logic [7:0] d);
      we_b = 1'b1; waddr_b = a; wdata_b = d;
      @(posedge clk); #1;
      we_b = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      we_a = 1'b0; waddr_a = 5'd0; wdata_a = 32'd0; ra1_a = 5'd0; ra2_a = 5'd0;
      we_b = 1'b0; waddr_b = 2'd0; wdata_b = 8'd0; ra1_b = 2'd0; ra2_b = 2'd0;
      #12;
      check("rst_wcount", 64'(wc_0), 64'd0);
      check("rst_wovf", 64'(wo_0), 64'd0);
      rst_n = 1'b1;

      // Asynchronous reset mid-cycle, then writes held off during reset.
      wr_a(5'd5, 32'hDEADBEEF);
      ra1_a = 5'd5; #1;
      check("pre_rst_rd", 64'(rd1_0), 64'hDEADBEEF);
      rst_n = 1'b0; #1;
      check("async_rst_rd1", 64'(rd1_0), 64'd0);
      check("async_rst_wc", 64'(wc_0), 64'd0);
      check("async_rst_ovf", 64'(wo_0), 64'd0);
      we_a = 1'b1; waddr_a = 5'd5; wdata_a = 32'h00001234; #1;
      check("rst_no_bypass", 64'(rd1_1), 64'd0);
      @(posedge clk); #1;
      check("rst_wr_ignored", 64'(rd1_0), 64'd0);
      check("rst_wr_nocount", 64'(wc_0), 64'd0);
      we_a = 1'b0;
      rst_n = 1'b1;

      // Basic write/read on two independent ports.
      wr_a(5'd3, 32'h12345678);
      wr_a(5'd31, 32'hCAFEF00D);
      ra1_a = 5'd3; ra2_a = 5'd31; #1;
      check("basic_rd1", 64'(rd1_0), 64'h12345678);
      check("basic_rd2", 64'(rd2_0), 64'hCAFEF00D);
      check("basic_wc", 64'(wc_0), 64'd2);
      ra2_a = 5'd3; #1;
      check("same_entry_rd2", 64'(rd2_1), 64'h12345678);

      // Entry 0: hardwired zero on dut0, ordinary on dut1.
      wr_a(5'd0, 32'hFFFFFFFF);
      ra1_a = 5'd0; #1;
      check("zero_rd_z1", 64'(rd1_0), 64'd0);
      check("zero_wc_z1", 64'(wc_0), 64'd2);
      check("zero_rd_z0", 64'(rd1_1), 64'hFFFFFFFF);
      check("zero_wc_z0", 64'(wc_1), 64'd3);

      // Bypass: entry 7 holds 1, write 2 with a read of 7 pending.
      wr_a(5'd7, 32'h1);
      we_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'h2; ra1_a = 5'd7; #1;
      check("nobyp_before", 64'(rd1_0), 64'h1);
      check("byp_before", 64'(rd1_1), 64'h2);
      @(posedge clk); #1;
      we_a = 1'b0;
      check("nobyp_after", 64'(rd1_0), 64'h2);
      check("byp_wc", 64'(wc_1), 64'd5);

      // Counter wrap on the 4-bit counter.
      for (int i = 0; i < 10; i++) begin
         wr_a(5'd9, 32'(i));
      end
      check("wrap15_wc", 64'(wc_1), 64'd15);
      check("wrap15_ovf", 64'(wo_1), 64'd0);
      check("wide_wc14", 64'(wc_0), 64'd14);
      wr_a(5'd9, 32'h10);
      check("wrap16_wc", 64'(wc_1), 64'd0);
      check("wrap16_ovf", 64'(wo_1), 64'd1);
      check("wide_ovf", 64'(wo_0), 64'd0);
      for (int i = 0; i < 3; i++) begin
         wr_a(5'd9, 32'(i + 32'd17));
      end
      check("wrap19_wc", 64'(wc_1), 64'd3);
      check("wrap19_ovf", 64'(wo_1), 64'd1);
      ra2_a = 5'd9; #1;
      check("last_data", 64'(rd2_0), 64'h13);
      @(posedge clk); #1;
      check("idle_nocount", 64'(wc_0), 64'd18);

      // Small geometry: zero beats bypass, plain bypass, then sweep.
      we_b = 1'b1; waddr_b = 2'd0; wdata_b = 8'hFF; ra1_b = 2'd0; #1;
      check("zero_over_byp", 64'(rd1_b), 64'd0);
      @(posedge clk); #1;
      we_b = 1'b0;
      we_b = 1'b1; waddr_b = 2'd2; wdata_b = 8'h3C; ra2_b = 2'd2; #1;
      check("small_byp", 64'(rd2_b), 64'h3C);
      @(posedge clk); #1;
      we_b = 1'b0;
      for (int a = 0; a < 4; a++) begin
         wr_b(2'(a), 8'hA5);
      end
      check("small_wc", 64'(wc_b), 64'd4);
      for (int a = 0; a < 4; a++) begin
         ra1_b = 2'(a); ra2_b = 2'(a); #1;
         check($sformatf("sweep_rd1_%0d", a), 64'(rd1_b), (a == 0) ? 64'd0 : 64'hA5);
         check($sformatf("sweep_rd2_%0d", a), 64'(rd2_b), (a == 0) ? 64'd0 : 64'hA5);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
